// File: rtl/fifo_pkg.sv
// Shared FIFO package: default data/pointer widths and read-stream buffer constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_PTR_WIDTH = 4;
    localparam int BUF_DEPTH     = 3;
    localparam int BUF_PTR_W     = 2;

    typedef logic [BUF_PTR_W-1:0] buf_ptr_t;
    typedef logic [1:0]           buf_cnt_t;

    typedef struct packed {
        buf_ptr_t wr_ptr;
        buf_ptr_t rd_ptr;
        buf_cnt_t held;
    } buf_state_t;

    // Circular increment over a non-power-of-two depth.
    function automatic buf_ptr_t buf_ptr_inc(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/stream_buf3.sv
// Three-entry circular skid buffer holding words returned by the FIFO read port.
// Latency: a pushed word is at the head the cycle after the push edge when the buffer was empty.
// Backpressure: caller must not push when full; pop is ignored while empty.
module stream_buf3
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output buf_cnt_t         held,
    output logic             not_empty
);
    buf_state_t       st;
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             pop_ok;

    assign pop_ok = pop && (st.held != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[st.wr_ptr] <= push_data;
                st.wr_ptr      <= buf_ptr_inc(st.wr_ptr);
            end
            if (pop_ok) begin
                st.rd_ptr <= buf_ptr_inc(st.rd_ptr);
            end
            // Simultaneous push and pop leaves the count untouched.
            case ({push, pop_ok})
                2'b10:   st.held <= st.held + buf_cnt_t'(1);
                2'b01:   st.held <= st.held - buf_cnt_t'(1);
                default: st.held <= st.held;
            endcase
        end
    end

    assign head_data = mem[st.rd_ptr];
    assign held      = st.held;
    assign not_empty = (st.held != '0);

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, 2**PTR_WIDTH entries, sticky error on overflow/underflow attempt.
// Latency: write visible (empty low) the cycle after the write edge; rdata registered one cycle after rd_en.
// Backpressure: full blocks writes, empty blocks reads; offending attempts set error.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             error
);
    localparam int DEPTH = 1 << PTR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0] wptr;
    logic [PTR_WIDTH:0] rptr;
    logic wr_ok;
    logic rd_ok;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                   (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[PTR_WIDTH-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
            error <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rdata <= mem[rptr[PTR_WIDTH-1:0]];
                rptr  <= rptr + 1'b1;
            end
            if ((wr_en && full) || (rd_en && empty)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine for sync_fifo: turns the registered-read port into a valid/ready stream.
// Latency: rd_en sampled at edge E, word captured at E+1, out_valid in the following cycle.
// Backpressure: issues reads only while buffered + in-flight words < 3; out_ready never reaches rd_en.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_rd_en,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] xfer_cnt,
    output logic                 busy
);
    logic     inflight;
    logic     pop;
    buf_cnt_t held;
    logic [2:0] occupancy;

    // Reserve a slot for every read already in flight so capture can never overflow.
    assign occupancy  = {1'b0, held} + {2'b00, inflight};
    assign fifo_rd_en = !fifo_empty && (occupancy < 3'(BUF_DEPTH));
    assign pop        = out_valid && out_ready;
    assign busy       = out_valid || inflight;

    stream_buf3 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (out_data),
        .held      (held),
        .not_empty (out_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench: sync_fifo feeding fifo_rd_stream (plus a 4-bit-counter twin), scoreboarded against a count/queue model.
// Latency: n/a.
// Backpressure: out_ready driven directed and randomly.
module tb_fifo_rd_stream;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        fifo_err;
    logic        fifo_rd_en;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [15:0] xfer_cnt;
    logic        busy;
    logic        fifo_rd_en4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  xfer_cnt4;
    logic        busy4;

    int checks = 0;
    int failures = 0;

    // Model state: words written since reset, reads issued, words delivered.
    logic [7:0] wlog [0:511];
    int   wr_n = 0;
    int   rd_cnt = 0;
    int   pop_idx = 0;
    logic prev_rd = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int   cyc = 0;
    int   pops_mark = 0;
    int   rd_mark = 0;
    int   first_pop_cyc = 0;
    int   last_pop_cyc = 0;
    logic [7:0] last_pop_dat = 8'h00;

    sync_fifo #(.WIDTH(8), .PTR_WIDTH(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .wdata (wdata),
        .full  (fifo_full),
        .rd_en (fifo_rd_en),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .error (fifo_err)
    );

    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .xfer_cnt   (xfer_cnt),
        .busy       (busy)
    );

    fifo_rd_stream #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en4),
        .out_valid  (out_valid4),
        .out_data   (out_data4),
        .out_ready  (out_ready),
        .xfer_cnt   (xfer_cnt4),
        .busy       (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        int   occ;
        logic exp_rd;
        logic exp_vld;
        if (!rst_n) begin
            rd_cnt     = 0;
            pop_idx    = 0;
            prev_rd    = 1'b0;
            prev_stall = 1'b0;
            prev_data  = 8'h00;
            return;
        end
        occ     = rd_cnt - pop_idx;
        exp_rd  = !fifo_empty && (occ < 3);
        exp_vld = (occ - int'(prev_rd)) != 0;
        check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        check("rd_en_w4", 32'(fifo_rd_en4), 32'(exp_rd));
        check("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'(0));
        check("out_valid", 32'(out_valid), 32'(exp_vld));
        check("out_valid_w4", 32'(out_valid4), 32'(exp_vld));
        check("busy", 32'(busy), 32'(occ != 0));
        check("busy_w4", 32'(busy4), 32'(occ != 0));
        check("fifo_error", 32'(fifo_err), 32'(0));
        check("xfer_cnt", 32'(xfer_cnt), 32'(pop_idx[15:0]));
        check("xfer_cnt_w4", 32'(xfer_cnt4), 32'(pop_idx[3:0]));
        if (out_valid) check("out_data_w4", 32'(out_data4), 32'(out_data));
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
            checks++;
            if (pop_idx >= wr_n) begin
                failures++;
                $display("FAIL extra_word: got %0h, expected no word (cycle %0d)", out_data, cyc);
            end else if (out_data !== wlog[pop_idx]) begin
                failures++;
                $display("FAIL data[%0d]: got %0h, expected %0h (cycle %0d)", pop_idx, out_data, wlog[pop_idx], cyc);
            end
            if (pops_mark == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            last_pop_dat = out_data;
            pops_mark++;
            pop_idx++;
        end
        if (fifo_rd_en) begin
            rd_cnt++;
            rd_mark++;
        end
        prev_rd    = fifo_rd_en;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_en = 1'b1;
        wdata = d;
        wlog[wr_n] = d;
        wr_n++;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pops_mark < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(pops_mark), 32'(n));
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wdata     = 8'h00;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle with an empty FIFO.
        repeat (20) tick();
        check("idle_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("idle_rd_count", 32'(rd_cnt), 32'(0));

        // Back-to-back stream, consumer always ready.
        out_ready = 1'b1;
        pops_mark = 0;
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        wait_pops(16, 100, "stream16_timeout");
        tick();
        check("stream16_xfer_cnt", 32'(xfer_cnt), 32'(16));
        check("stream16_consecutive", 32'(last_pop_cyc - first_pop_cyc), 32'(15));
        check("stream16_last", 32'(last_pop_dat), 32'(8'h10));

        // Backpressure: only three words leave the FIFO.
        out_ready = 1'b0;
        pops_mark = 0;
        rd_mark   = 0;
        push_word(8'hA5);
        push_word(8'h3C);
        push_word(8'hF0);
        push_word(8'h11);
        repeat (10) tick();
        check("bp_reads", 32'(rd_mark), 32'(3));
        check("bp_head", 32'(out_data), 32'(8'hA5));
        check("bp_valid", 32'(out_valid), 32'(1));
        check("bp_fifo_nonempty", 32'(fifo_empty), 32'(0));
        out_ready = 1'b1;
        wait_pops(4, 50, "bp_drain_timeout");
        tick();
        check("bp_last", 32'(last_pop_dat), 32'(8'h11));
        check("bp_xfer_cnt", 32'(xfer_cnt), 32'(20));

        // Random producer and consumer.
        pops_mark = 0;
        begin
            int sent;
            int k;
            sent = 0;
            k = 0;
            while ((sent < 200 || pops_mark < 200) && k < 5000) begin
                out_ready = 1'($urandom_range(0, 1));
                if (sent < 200 && !fifo_full && $urandom_range(0, 1) == 1) begin
                    wr_en = 1'b1;
                    wdata = 8'($urandom);
                    wlog[wr_n] = wdata;
                    wr_n++;
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
                k++;
            end
            wr_en = 1'b0;
            check("rand_sent", 32'(sent), 32'(200));
            check("rand_pops", 32'(pops_mark), 32'(200));
        end
        out_ready = 1'b1;
        repeat (5) tick();
        check("rand_xfer_cnt", 32'(xfer_cnt), 32'(220));
        check("rand_xfer_cnt_w4", 32'(xfer_cnt4), 32'(12));

        // Reset with two words held.
        out_ready = 1'b0;
        push_word(8'hB1);
        push_word(8'hB2);
        repeat (5) tick();
        check("pre_rst_held", 32'(rd_cnt - pop_idx), 32'(2));
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'(0));
        check("rst_xfer_cnt_w4", 32'(xfer_cnt4), 32'(0));
        wr_n = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // First word after reset, then wrap the 4-bit counter at 17 transfers.
        out_ready = 1'b1;
        pops_mark = 0;
        push_word(8'h77);
        wait_pops(1, 20, "post_rst_timeout");
        check("post_rst_first", 32'(last_pop_dat), 32'(8'h77));
        for (int i = 0; i < 16; i++) push_word(8'(8'h80 + i));
        wait_pops(17, 100, "wrap_timeout");
        tick();
        check("wrap_xfer_cnt", 32'(xfer_cnt), 32'(17));
        check("wrap_xfer_cnt_w4", 32'(xfer_cnt4), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side engine for the team's synchronous FIFO (`sync_fifo`). It drives the FIFO read port (`rd_en`, `rdata`, `empty`) and hides the FIFO's one-cycle registered read latency. Downstream logic sees a plain valid/ready stream at up to one word per clock. It sits between `sync_fifo` and any consumer, and never underflows the FIFO, so the FIFO's `error` output stays low.

## Interface
- WIDTH, 8, data word width; must match the FIFO's WIDTH
- CNT_WIDTH, 16, width of the transfer counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO `empty`
- fifo_rdata  in  WIDTH  FIFO `rdata`; valid in the cycle after `fifo_rd_en` was sampled high
- fifo_rd_en  out  WIDTH=1  FIFO `rd_en`
- out_valid  out  1  `out_data` holds a word
- out_data  out  WIDTH  head word
- out_ready  in  1  consumer accepts the head word this cycle
- xfer_cnt  out  CNT_WIDTH  count of completed output transfers
- busy  out  1  a word is buffered or in flight

## Operation
- Internal 3-entry circular buffer:
  - write pointer (2b), read pointer (2b), `held` count (0..3)
  - `inflight` flag (1b): a FIFO read issued last cycle whose data arrives this cycle
- Read issue, combinational from registered state:
  - `fifo_rd_en = !fifo_empty && (held + inflight < 3)`
  - No path from `out_ready` to `fifo_rd_en`.
- Each edge:
  - `inflight <= fifo_rd_en`
  - If `inflight`: write `fifo_rdata` at the write pointer and increment it.
  - If `out_valid && out_ready`: increment the read pointer and increment `xfer_cnt`.
  - `held` += inflight − pop. Simultaneous capture and pop leaves `held` unchanged.
- Pointer wrap: 2 → 0, both pointers.
- `out_valid = (held != 0)`; `out_data` = buffer[read pointer], both driven from registers.
- `out_data` holds stable while `out_valid && !out_ready`. Once asserted, `out_valid` never drops without a pop.
- `busy = (held != 0) || inflight`
- `xfer_cnt` wraps modulo 2^CNT_WIDTH with no saturation.
- Guarantees:
  - Words are delivered in FIFO order.
  - No word is dropped or duplicated.
  - `fifo_rd_en` is never high while `fifo_empty` is high.

## Timing
- Reset (async assert, sync release): pointers = 0, `held` = 0, `inflight` = 0, `xfer_cnt` = 0. Outputs: `out_valid` = 0, `out_data` = 0, `busy` = 0, `fifo_rd_en` = 0.
- Reset mid-operation: buffered and in-flight words are discarded. Any FIFO word already popped is lost. The FIFO shares `rst_n` and is cleared at the same time.
- Latency: `fifo_rd_en` sampled at edge E → word captured at E+1 → `out_valid` high in the cycle after E+1.
- Empty FIFO with its first write at edge W:
  - `fifo_empty` falls after W
  - `fifo_rd_en` high in the same cycle
  - `out_valid` high after W+2
- Throughput: with `out_ready` held high and the FIFO non-empty, one transfer per cycle is sustained after the 2-cycle fill.
- Backpressure: with `out_ready` low, at most 3 words are taken from the FIFO. `fifo_rd_en` then stays low until a pop.
- Boundary cases:
  - `held` = 3: no issue.
  - `held` = 2 with `inflight` = 1: no issue.
  - Pop and capture on the same edge with `held` = 3: not reachable by construction.

## Structure
- Shared package `fifo_pkg` holds:
  - default WIDTH and PTR_WIDTH, shared with `sync_fifo`
  - localparam BUF_DEPTH = 3
- One sub-module is natural: `stream_buf3`, the 3-entry circular buffer with push/pop/count. The top level holds the issue logic, `inflight` and `xfer_cnt`.

## Test plan
- Reset, FIFO empty for 20 cycles → `fifo_rd_en`, `out_valid`, `busy` stay 0; `xfer_cnt` = 0.
- Write 16 words 0x01..0x10 back-to-back with `out_ready` = 1 → 16 transfers in order 0x01..0x10. After the first, they arrive on consecutive cycles; `xfer_cnt` = 16. FIFO `error` never asserts.
- Write 0xA5, 0x3C, 0xF0, 0x11 with `out_ready` = 0 → exactly 3 FIFO reads, `out_data` = 0xA5 stable, FIFO holds 1 word. Raise `out_ready` → 0xA5, 0x3C, 0xF0, 0x11 delivered.
- Random `out_ready` (50%) against concurrent random-delay FIFO writes of 200 words → scoreboard order match, no loss or duplication. `fifo_rd_en && fifo_empty` never seen.
- Deassert `rst_n` mid-stream with 2 words held → all outputs 0 immediately, asynchronously. After release, the first new word written (0x77) is delivered with no stale data.
- CNT_WIDTH = 4, 17 transfers → `xfer_cnt` = 1 (wrap).
